// File: rtl/filter_video_pkg.sv
// Shared definitions for the filter video source.
// Holds the FSM state encoding, the test-pattern select codes and the
// fixed pixel constants used by the pattern generator.
package filter_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FIDX  = 2'd3
  } pat_t;

  localparam int unsigned CHROMA_NEUTRAL = 'h80;
  localparam int unsigned CHK_HI         = 235;
  localparam int unsigned CHK_LO         = 16;

endpackage

// File: rtl/filter_raster_cnt.sv
// Raster timing counters for the video source.
// Horizontal/vertical counters that wrap at the programmed totals, plus the
// frame-end flag and the combinational sync/data-enable/position decode.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   clr              synchronous clear of both counters (frame start)
//   en               advance the counters by one clock
//   h_*/v_*          latched field lengths (already clamped to >= 1)
//   frame_end        counter sits on the last clock of the last line
//   hs, vs, de       decode of the current counter state
//   x, y             position inside the active area (low PW bits)
module filter_raster_cnt #(
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 12,
  parameter int PW      = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               en,
  input  logic [H_WIDTH-1:0] h_sync,
  input  logic [H_WIDTH-1:0] h_bp,
  input  logic [H_WIDTH-1:0] h_act,
  input  logic [H_WIDTH-1:0] h_fp,
  input  logic [V_WIDTH-1:0] v_sync,
  input  logic [V_WIDTH-1:0] v_bp,
  input  logic [V_WIDTH-1:0] v_act,
  input  logic [V_WIDTH-1:0] v_fp,
  output logic               frame_end,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [PW-1:0]      x,
  output logic [PW-1:0]      y
);

  // Two extra bits so the sum of four fields never overflows.
  localparam int HC = H_WIDTH + 2;
  localparam int VC = V_WIDTH + 2;

  logic [HC-1:0] hcnt, htot, h_act_start, h_act_end;
  logic [VC-1:0] vcnt, vtot, v_act_start, v_act_end;
  logic          line_end;

  assign h_act_start = HC'(h_sync) + HC'(h_bp);
  assign h_act_end   = h_act_start + HC'(h_act);
  assign htot        = h_act_end + HC'(h_fp);
  assign v_act_start = VC'(v_sync) + VC'(v_bp);
  assign v_act_end   = v_act_start + VC'(v_act);
  assign vtot        = v_act_end + VC'(v_fp);

  assign line_end  = (hcnt == htot - HC'(1));
  assign frame_end = line_end && (vcnt == vtot - VC'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (clr) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= (vcnt == vtot - VC'(1)) ? '0 : vcnt + VC'(1);
      end else begin
        hcnt <= hcnt + HC'(1);
      end
    end
  end

  assign hs = (hcnt < HC'(h_sync));
  assign vs = (vcnt < VC'(v_sync));
  assign de = (vcnt >= v_act_start) && (vcnt < v_act_end) &&
              (hcnt >= h_act_start) && (hcnt < h_act_end);
  // Only meaningful while de is high; outside the active area the value wraps.
  assign x  = PW'(hcnt - h_act_start);
  assign y  = PW'(vcnt - v_act_start);

endmodule

// File: rtl/filter_video_src.sv
// Raster video source: emits programmable vs/hs/de timing with a selectable
// Y/U/V test pattern, for driving filter blocks in benches and BIST.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   i_start                start pulse (accepted in IDLE only)
//   i_stop                 finish after the current frame (sticky in RUN)
//   i_frame_num            frames to send, 0 = until stopped
//   i_pat_sel              0 h-ramp, 1 v-ramp, 2 checker, 3 frame index
//   i_h_*/i_v_*            field lengths in clocks / lines (0 acts as 1)
//   o_busy, o_done         frame activity / one-cycle end-of-run pulse
//   o_vs, o_hs, o_de       registered syncs and data enable
//   o_y, o_u, o_v          registered pixel components
module filter_video_src
  import filter_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_WIDTH    = 12,
  parameter int V_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [7:0]            i_frame_num,
  input  logic [1:0]            i_pat_sel,
  input  logic [H_WIDTH-1:0]    i_h_sync,
  input  logic [H_WIDTH-1:0]    i_h_bp,
  input  logic [H_WIDTH-1:0]    i_h_act,
  input  logic [H_WIDTH-1:0]    i_h_fp,
  input  logic [V_WIDTH-1:0]    i_v_sync,
  input  logic [V_WIDTH-1:0]    i_v_bp,
  input  logic [V_WIDTH-1:0]    i_v_act,
  input  logic [V_WIDTH-1:0]    i_v_fp,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_u,
  output logic [DATA_WIDTH-1:0] o_v
);

  function automatic logic [H_WIDTH-1:0] clamp_h(input logic [H_WIDTH-1:0] f);
    return (f == '0) ? H_WIDTH'(1) : f;
  endfunction

  function automatic logic [V_WIDTH-1:0] clamp_v(input logic [V_WIDTH-1:0] f);
    return (f == '0) ? V_WIDTH'(1) : f;
  endfunction

  state_t               state, state_nxt;
  pat_t                 pat_q;
  logic [7:0]           frame_num_q;
  logic [7:0]           fidx;
  logic                 stop_pend;
  logic [H_WIDTH-1:0]   h_sync_q, h_bp_q, h_act_q, h_fp_q;
  logic [V_WIDTH-1:0]   v_sync_q, v_bp_q, v_act_q, v_fp_q;

  logic                 start_go, run, frame_end, last_frame, stop_now;
  logic                 hs_c, vs_c, de_c;
  logic [DATA_WIDTH-1:0] x_c, y_c, pix_y;

  assign start_go   = (state == ST_IDLE) && i_start;
  assign run        = (state == ST_RUN);
  assign last_frame = (frame_num_q != 8'd0) && (fidx + 8'd1 == frame_num_q);
  // A stop arriving on the frame-end cycle itself still counts.
  assign stop_now   = stop_pend || i_stop;

  filter_raster_cnt #(
    .H_WIDTH (H_WIDTH),
    .V_WIDTH (V_WIDTH),
    .PW      (DATA_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (start_go),
    .en        (run),
    .h_sync    (h_sync_q),
    .h_bp      (h_bp_q),
    .h_act     (h_act_q),
    .h_fp      (h_fp_q),
    .v_sync    (v_sync_q),
    .v_bp      (v_bp_q),
    .v_act     (v_act_q),
    .v_fp      (v_fp_q),
    .frame_end (frame_end),
    .hs        (hs_c),
    .vs        (vs_c),
    .de        (de_c),
    .x         (x_c),
    .y         (y_c)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end && (last_frame || stop_now)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_y = '0;
    case (pat_q)
      PAT_HRAMP: pix_y = x_c;
      PAT_VRAMP: pix_y = y_c;
      PAT_CHECK: pix_y = (x_c[3] ^ y_c[3]) ? DATA_WIDTH'(CHK_HI) : DATA_WIDTH'(CHK_LO);
      PAT_FIDX:  pix_y = DATA_WIDTH'(fidx);
      default:   pix_y = '0;
    endcase
  end

  // NOTE: the latched configuration is reset along with the control state;
  // it is a handful of flops, not a memory, so a known value costs nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      pat_q       <= PAT_HRAMP;
      frame_num_q <= '0;
      fidx        <= '0;
      stop_pend   <= 1'b0;
      h_sync_q    <= '0;
      h_bp_q      <= '0;
      h_act_q     <= '0;
      h_fp_q      <= '0;
      v_sync_q    <= '0;
      v_bp_q      <= '0;
      v_act_q     <= '0;
      v_fp_q      <= '0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        pat_q       <= pat_t'(i_pat_sel);
        frame_num_q <= i_frame_num;
        fidx        <= '0;
        h_sync_q    <= clamp_h(i_h_sync);
        h_bp_q      <= clamp_h(i_h_bp);
        h_act_q     <= clamp_h(i_h_act);
        h_fp_q      <= clamp_h(i_h_fp);
        v_sync_q    <= clamp_v(i_v_sync);
        v_bp_q      <= clamp_v(i_v_bp);
        v_act_q     <= clamp_v(i_v_act);
        v_fp_q      <= clamp_v(i_v_fp);
      end else if (run && frame_end) begin
        fidx <= fidx + 8'd1;
      end
      // Stop is only remembered while frames are running.
      if (run && i_stop) stop_pend <= 1'b1;
      else if (!run)     stop_pend <= 1'b0;
    end
  end

  // Output register: the pixel for counter state (h,v) leaves one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_vs   <= 1'b0;
      o_hs   <= 1'b0;
      o_de   <= 1'b0;
      o_y    <= '0;
      o_u    <= '0;
      o_v    <= '0;
    end else if (run) begin
      o_busy <= 1'b1;
      o_done <= 1'b0;
      o_vs   <= vs_c;
      o_hs   <= hs_c;
      o_de   <= de_c;
      o_y    <= de_c ? pix_y : '0;
      o_u    <= de_c ? DATA_WIDTH'(CHROMA_NEUTRAL) : '0;
      o_v    <= de_c ? DATA_WIDTH'(CHROMA_NEUTRAL) : '0;
    end else begin
      o_busy <= 1'b0;
      o_done <= (state == ST_DONE);
      o_vs   <= 1'b0;
      o_hs   <= 1'b0;
      o_de   <= 1'b0;
      o_y    <= '0;
      o_u    <= '0;
      o_v    <= '0;
    end
  end

endmodule
